// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display path: glyph table,
// segment bit order and the value-register operation select.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_PUSH
  } value_op_e;

  function automatic value_op_e sel_op(input logic clear_i, input logic load_i,
                                       input logic push_i);
    if (clear_i)     return OP_CLEAR;
    else if (load_i) return OP_LOAD;
    else if (push_i) return OP_PUSH;
    else             return OP_HOLD;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment glyph.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph;

  assign glyph = SEG_GLYPH[nibble_i];

  assign seg_o[SEG_A] = glyph[SEG_A];
  assign seg_o[SEG_B] = glyph[SEG_B];
  assign seg_o[SEG_C] = glyph[SEG_C];
  assign seg_o[SEG_D] = glyph[SEG_D];
  assign seg_o[SEG_E] = glyph[SEG_E];
  assign seg_o[SEG_F] = glyph[SEG_F];
  assign seg_o[SEG_G] = glyph[SEG_G];

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit seven-segment driver: held hex value with load/shift entry,
// leading-zero blanking, per-digit enable, timed blink, registered segments.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    push,
  input  logic [3:0]              push_digit,
  input  logic                    clear,
  input  logic                    lz_blank_en,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [3:0]              digit_count,
  output logic                    overflow
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned SW = 7 * NUM_DIGITS;
  localparam int unsigned CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("hex_display_driver: NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("hex_display_driver: BLINK_DIV must be >= 2");
  end

  logic [VW-1:0] value_q, value_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [SW-1:0] hex_q, hex_d;

  logic [NUM_DIGITS-1:0] blank;
  logic [6:0]            seg_raw [NUM_DIGITS];

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (sel_op(clear, load, push))
      OP_CLEAR: begin
        value_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end
      OP_LOAD: begin
        value_d = load_value;
        count_d = 4'(NUM_DIGITS);
      end
      OP_PUSH: begin
        value_d = (value_q << 4) | VW'(push_digit);
        if (count_q < 4'(NUM_DIGITS)) count_d = count_q + 4'd1;
        else                          ovf_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + CW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Digit i is zero-blanked only when it and every more significant nibble are zero
  always_comb begin
    logic lz_zero;
    blank   = '0;
    lz_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lz_zero = 1'b1;
      for (int unsigned j = i; j < NUM_DIGITS; j++) begin
        lz_zero = lz_zero & (value_q[4*j +: 4] == 4'h0);
      end
      blank[i] = ~digit_en[i]
               | (blink_en & blink_mask[i] & phase_q)
               | (lz_blank_en & (i != 0) & lz_zero);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_seg_decode u_dec (
      .nibble_i (value_q[4*g +: 4]),
      .seg_o    (seg_raw[g])
    );
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = blank[i] ? SEG_BLANK : seg_raw[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hex_q       <= '1;
    end else begin
      value_q     <= value_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_q       <= hex_d;
    end
  end

  assign hex_out     = hex_q;
  assign value_out   = value_q;
  assign digit_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench for hex_display_driver: per-cycle expectations from a
// digit-array reference model, compared by an independent negedge monitor.
module tb_hex_display_driver;

  localparam int unsigned N  = 6;
  localparam int unsigned BD = 4;

  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic          reset;
    logic          clear;
    logic          load;
    logic          push;
    logic [4*N-1:0] load_value;
    logic [3:0]    push_digit;
    logic          lz;
    logic          be;
    logic [N-1:0]  mask;
    logic [N-1:0]  de;
  } stim_t;

  typedef struct {
    logic [4*N-1:0] val;
    logic [3:0]     cnt;
    logic           ovf;
    logic [7*N-1:0] hex;
  } exp_t;

  logic           clock;
  logic           reset;
  logic           load;
  logic [4*N-1:0] load_value;
  logic           push;
  logic [3:0]     push_digit;
  logic           clear;
  logic           lz_blank_en;
  logic           blink_en;
  logic [N-1:0]   blink_mask;
  logic [N-1:0]   digit_en;
  logic [7*N-1:0] hex_out;
  logic [4*N-1:0] value_out;
  logic [3:0]     digit_count;
  logic           overflow;

  hex_display_driver #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .push        (push),
    .push_digit  (push_digit),
    .clear       (clear),
    .lz_blank_en (lz_blank_en),
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .digit_en    (digit_en),
    .hex_out     (hex_out),
    .value_out   (value_out),
    .digit_count (digit_count),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Reference model state
  int unsigned    m_dig [N];
  int unsigned    m_cnt;
  bit             m_ovf;
  longint         m_edges;
  logic [7*N-1:0] m_hex;
  stim_t          cur;

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.clear = 0; s.load = 0; s.push = 0;
    s.load_value = '0; s.push_digit = '0;
    s.lz = 0; s.be = 0; s.mask = '0; s.de = '1;
    return s;
  endfunction

  function automatic logic [7*N-1:0] render();
    logic [7*N-1:0] r;
    int msd = 0;
    bit phase;
    bit blank;
    phase = ((m_edges / BD) % 2) == 1;
    for (int j = 0; j < N; j++) if (m_dig[j] != 0) msd = j;
    for (int i = 0; i < N; i++) begin
      blank = !cur.de[i] || (cur.be && cur.mask[i] && phase) || (cur.lz && i > msd);
      r[7*i +: 7] = blank ? 7'h7F : GLY[m_dig[i]];
    end
    return r;
  endfunction

  function automatic logic [4*N-1:0] pack_val();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_cnt = 0; m_ovf = 0; m_edges = 0; m_hex = '1;
  endtask

  task automatic model_edge();
    if (cur.reset) return;
    m_hex = render();
    if (cur.clear) begin
      for (int i = 0; i < N; i++) m_dig[i] = 0;
      m_cnt = 0; m_ovf = 0;
    end else if (cur.load) begin
      for (int i = 0; i < N; i++) m_dig[i] = int'(cur.load_value[4*i +: 4]);
      m_cnt = N;
    end else if (cur.push) begin
      if (m_cnt == N) m_ovf = 1; else m_cnt++;
      for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
      m_dig[0] = int'(cur.push_digit);
    end
    m_edges++;
  endtask

  task automatic drive(input stim_t s);
    reset = s.reset; clear = s.clear; load = s.load; push = s.push;
    load_value = s.load_value; push_digit = s.push_digit;
    lz_blank_en = s.lz; blink_en = s.be; blink_mask = s.mask; digit_en = s.de;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    model_edge();
    cur = s;
    drive(s);
    if (s.reset) model_reset();
    e.val = pack_val(); e.cnt = 4'(m_cnt); e.ovf = m_ovf; e.hex = m_hex;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("value_out",   64'(value_out),   64'(e.val));
      chk("digit_count", 64'(digit_count), 64'(e.cnt));
      chk("overflow",    64'(overflow),    64'(e.ovf));
      chk("hex_out",     64'(hex_out),     64'(e.hex));
    end
  end

  initial begin
    stim_t s;
    cur = idle();
    cur.reset = 1;
    drive(cur);
    model_reset();

    s = idle(); s.reset = 1;
    repeat (3) step(s);
    s.reset = 0;
    repeat (2) step(s);

    s = idle(); s.lz = 1; s.load = 1; s.load_value = 24'h0012AB;
    step(s);
    s.load = 0;
    repeat (3) step(s);

    s = idle(); s.clear = 1; step(s);
    s.clear = 0;
    for (int unsigned d = 1; d <= 7; d++) begin
      s.push = 1; s.push_digit = 4'(d); step(s);
    end
    s.push = 0; repeat (2) step(s);
    s.clear = 1; step(s);
    s.clear = 0; repeat (2) step(s);

    s = idle(); s.load = 1; s.push = 1; s.load_value = 24'hFFFFFF; s.push_digit = 4'h3;
    step(s);
    s = idle(); repeat (2) step(s);

    s = idle(); s.load = 1; s.load_value = 24'h000008; step(s);
    s.load = 0; s.be = 1; s.mask = 6'b000001;
    repeat (20) step(s);

    s = idle(); s.clear = 1; s.lz = 1; step(s);
    s.clear = 0; repeat (3) step(s);
    s.de[0] = 1'b0; repeat (3) step(s);

    for (int unsigned n = 0; n < 1500; n++) begin
      logic [4*N-1:0] lv;
      s = idle();
      s.reset = ($urandom_range(0, 199) == 0);
      s.clear = ($urandom_range(0, 29) == 0);
      s.load  = ($urandom_range(0, 7) == 0);
      s.push  = ($urandom_range(0, 2) == 0);
      lv = 24'($urandom);
      s.load_value = lv >> (4 * $urandom_range(0, N));
      s.push_digit = 4'($urandom);
      s.lz   = 1'($urandom);
      s.be   = 1'($urandom);
      s.mask = N'($urandom);
      s.de   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      step(s);
    end

    s = idle(); repeat (2) step(s);
    repeat (3) @(negedge clock);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
